// File: rtl/bm_serializer_if.sv
// Handshake bundle between the bitonic merger, the serializer and the downstream consumer.
// No logic inside: wires only, zero latency.
// Upstream side stalls on in_ready; the downstream side stalls the element stream with out_ready.
interface bm_serializer_if #(
  parameter int LP = 3,
  parameter int DW = 8
);
  localparam int PN = 1 << LP;

  logic              in_valid;
  logic              in_ready;
  logic [PN*DW-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [LP-1:0]     out_idx;
  logic              out_last;
  logic              sort_err;

  // Producer/consumer view (testbench or surrounding fabric)
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, sort_err
  );

  // Serializer view
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, sort_err
  );
endinterface

// File: rtl/bm_serializer.sv
// Double-buffered parallel-to-serial stage for merged vectors, with a sticky in-vector order checker.
// Latency: first element valid the cycle after the vector is accepted into an empty buffer; 1 element/cycle sustained.
// Backpressure: in_ready drops only while both slots are full (no look-ahead); out_ready low freezes the current element.
module bm_serializer #(
  parameter int LP  = 3,
  parameter int DW  = 8,
  parameter int DIR = 0,
  parameter int REV = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  bm_serializer_if.slave   bus
);
  localparam int            PN       = 1 << LP;
  localparam logic [LP-1:0] LAST_CNT = LP'(PN - 1);
  // Emission runs with the sort direction when DIR==REV, so the stream must not decrease.
  localparam bit            ASCEND   = (DIR == REV);

  logic [PN*DW-1:0] slot0_q, slot0_d;
  logic [PN*DW-1:0] slot1_q, slot1_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [LP-1:0]    ecnt_q, ecnt_d;
  logic [DW-1:0]    prev_q, prev_d;
  logic             prev_v_q, prev_v_d;
  logic             sort_err_q, sort_err_d;

  logic [PN*DW-1:0] rd_vec;
  logic [LP-1:0]    cur_idx;
  logic [DW-1:0]    sel_elem;
  logic [DW-1:0]    cur_dat;
  logic             out_vld;
  logic             in_rdy;
  logic             is_last;
  logic             acc;
  logic             pop;

  // Output decode: purely from registered state, element muxed out of the read slot
  always_comb begin
    rd_vec   = rd_ptr_q ? slot1_q : slot0_q;
    cur_idx  = (REV != 0) ? ~ecnt_q : ecnt_q;
    sel_elem = '0;
    for (int i = 0; i < PN; i++) begin
      if (cur_idx == LP'(i)) sel_elem = rd_vec[i*DW +: DW];
    end
    out_vld = (count_q != 2'd0);
    in_rdy  = (count_q != 2'd2);
    is_last = out_vld && (ecnt_q == LAST_CNT);
    // Empty buffer must present zero, whatever stale contents the slots hold
    cur_dat = out_vld ? sel_elem : '0;
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_data  = cur_dat;
  assign bus.out_idx   = cur_idx;
  assign bus.out_last  = is_last;
  assign bus.sort_err  = sort_err_q;

  // Next-state: slot fill on accept, element advance / slot release on pop, order check
  always_comb begin
    slot0_d    = slot0_q;
    slot1_d    = slot1_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ecnt_d     = ecnt_q;
    prev_d     = prev_q;
    prev_v_d   = prev_v_q;
    sort_err_d = sort_err_q;

    acc = bus.in_valid && in_rdy;
    pop = out_vld && bus.out_ready;

    if (acc) begin
      if (wr_ptr_q) slot1_d = bus.in_data;
      else          slot0_d = bus.in_data;
      wr_ptr_d = ~wr_ptr_q;
    end

    if (pop) begin
      if (prev_v_q && (ASCEND ? (cur_dat < prev_q) : (cur_dat > prev_q))) sort_err_d = 1'b1;
      prev_d   = cur_dat;
      // Last element closes the vector so the next vector's first element is never compared
      prev_v_d = ~is_last;
      if (is_last) begin
        ecnt_d   = '0;
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        ecnt_d = ecnt_q + 1'b1;
      end
    end

    case ({acc, pop && is_last})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers, all cleared by the asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q    <= '0;
      slot1_q    <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      ecnt_q     <= '0;
      prev_q     <= '0;
      prev_v_q   <= 1'b0;
      sort_err_q <= 1'b0;
    end else begin
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ecnt_q     <= ecnt_d;
      prev_q     <= prev_d;
      prev_v_q   <= prev_v_d;
      sort_err_q <= sort_err_d;
    end
  end
endmodule

// File: tb/tb_bm_serializer.sv
// Bench for bm_serializer: two instances (REV=0 and REV=1, DIR=0) share one stimulus stream.
// A queue-based model predicts every output each cycle; directed literals pin the model.
// Handshake driven at posedge+1, outputs compared at negedge.
module tb_bm_serializer;
  localparam int LP = 3;
  localparam int DW = 8;
  localparam int PN = 8;

  typedef struct {
    logic [DW-1:0] d;
    logic [LP-1:0] idx;
    logic          last;
  } elem_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [PN*DW-1:0] in_data = '0;
  logic out_ready = 1'b0;
  bit   chk_en = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bm_serializer_if #(.LP(LP), .DW(DW)) bus0 ();
  bm_serializer_if #(.LP(LP), .DW(DW)) bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.in_data   = in_data;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_data   = in_data;
  assign bus1.out_ready = out_ready;

  bm_serializer #(.LP(LP), .DW(DW), .DIR(0), .REV(0)) u_fwd (.clk(clk), .rst_n(rst_n), .bus(bus0));
  bm_serializer #(.LP(LP), .DW(DW), .DIR(0), .REV(1)) u_rev (.clk(clk), .rst_n(rst_n), .bus(bus1));

  logic          d_rdy  [2];
  logic          d_vld  [2];
  logic [DW-1:0] d_data [2];
  logic [LP-1:0] d_idx  [2];
  logic          d_last [2];
  logic          d_err  [2];

  assign d_rdy[0]  = bus0.in_ready;
  assign d_vld[0]  = bus0.out_valid;
  assign d_data[0] = bus0.out_data;
  assign d_idx[0]  = bus0.out_idx;
  assign d_last[0] = bus0.out_last;
  assign d_err[0]  = bus0.sort_err;
  assign d_rdy[1]  = bus1.in_ready;
  assign d_vld[1]  = bus1.out_valid;
  assign d_data[1] = bus1.out_data;
  assign d_idx[1]  = bus1.out_idx;
  assign d_last[1] = bus1.out_last;
  assign d_err[1]  = bus1.sort_err;

  // Model state: pending elements in emission order, vectors held, checker state, popped log
  elem_t         mq    [2][$];
  int            nvec  [2];
  bit            merr  [2];
  logic [DW-1:0] mprev [2];
  bit            mprev_v [2];
  logic [DW-1:0] seen  [2][$];

  task automatic check(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d got=%0d expected=%0d t=%0t", name, u, act, exp, $time);
    end
  endtask

  // Model update on each clock edge from the bench's own view of the handshake
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int u = 0; u < 2; u++) begin
        mq[u].delete();
        nvec[u] = 0;
        merr[u] = 1'b0;
        mprev[u] = '0;
        mprev_v[u] = 1'b0;
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        bit    acc;
        bit    pop;
        bit    asc;
        elem_t e;
        acc = in_valid && (nvec[u] < 2);
        pop = out_ready && (mq[u].size() > 0);
        asc = (u == 0);
        if (pop) begin
          e = mq[u].pop_front();
          seen[u].push_back(e.d);
          if (mprev_v[u] && (asc ? (e.d < mprev[u]) : (e.d > mprev[u]))) merr[u] = 1'b1;
          mprev[u] = e.d;
          mprev_v[u] = !e.last;
          if (e.last) nvec[u]--;
        end
        if (acc) begin
          for (int k = 0; k < PN; k++) begin
            int ix;
            ix = (u == 1) ? (PN - 1 - k) : k;
            e.d = in_data[ix*DW +: DW];
            e.idx = LP'(ix);
            e.last = (k == PN - 1);
            mq[u].push_back(e);
          end
          nvec[u]++;
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int u = 0; u < 2; u++) begin
        check("in_ready", u, 32'(d_rdy[u]), 32'(nvec[u] < 2));
        check("out_valid", u, 32'(d_vld[u]), 32'(mq[u].size() > 0));
        check("sort_err", u, 32'(d_err[u]), 32'(merr[u]));
        if (mq[u].size() > 0) begin
          check("out_data", u, 32'(d_data[u]), 32'(mq[u][0].d));
          check("out_idx", u, 32'(d_idx[u]), 32'(mq[u][0].idx));
          check("out_last", u, 32'(d_last[u]), 32'(mq[u][0].last));
        end else begin
          check("idle_data", u, 32'(d_data[u]), 32'd0);
          check("idle_last", u, 32'(d_last[u]), 32'd0);
        end
      end
    end
  end

  function automatic logic [PN*DW-1:0] ramp(input int base);
    logic [PN*DW-1:0] v;
    for (int i = 0; i < PN; i++) v[i*DW +: DW] = DW'(base + i);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a vector and hold it until the edge that accepts it
  task automatic push(input logic [PN*DW-1:0] v);
    bit acc;
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_data = v;
    for (int t = 0; t < 200 && !done; t++) begin
      acc = (nvec[0] < 2);
      step();
      if (acc) done = 1'b1;
    end
    in_valid = 1'b0;
    if (!done) check("push_timeout", 0, 32'd0, 32'd1);
  endtask

  task automatic wait_seen(input int n);
    int t;
    t = 0;
    while (seen[0].size() < n && t < 400) begin
      step();
      t++;
    end
    if (seen[0].size() < n) check("drain_timeout", 0, 32'(seen[0].size()), 32'(n));
  endtask

  task automatic clear_seen();
    seen[0].delete();
    seen[1].delete();
  endtask

  initial begin
    logic [PN*DW-1:0] v;
    step();
    step();
    // Reset values (REV=0 instance has out_idx 0 in reset)
    check("rst_in_ready", 0, 32'(d_rdy[0]), 32'd1);
    check("rst_out_valid", 0, 32'(d_vld[0]), 32'd0);
    check("rst_out_last", 0, 32'(d_last[0]), 32'd0);
    check("rst_out_idx", 0, 32'(d_idx[0]), 32'd0);
    check("rst_out_data", 0, 32'(d_data[0]), 32'd0);
    check("rst_sort_err", 0, 32'(d_err[0]), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    step();

    // Ramp 0..7 with the sink always ready
    out_ready = 1'b1;
    clear_seen();
    push(ramp(0));
    check("first_lat_valid", 0, 32'(d_vld[0]), 32'd1);
    check("first_lat_data", 0, 32'(d_data[0]), 32'd0);
    check("first_lat_data_rev", 1, 32'(d_data[1]), 32'd7);
    check("first_lat_idx_rev", 1, 32'(d_idx[1]), 32'd7);
    wait_seen(8);
    for (int k = 0; k < 8; k++) begin
      check("ramp_fwd", 0, 32'(seen[0][k]), 32'(k));
      check("ramp_rev", 1, 32'(seen[1][k]), 32'(7 - k));
    end
    check("ramp_err_fwd", 0, 32'(d_err[0]), 32'd0);
    check("ramp_err_rev", 1, 32'(d_err[1]), 32'd0);

    // Two vectors buffered while the sink stalls, then drained without a bubble
    out_ready = 1'b0;
    step();
    clear_seen();
    push(ramp(10));
    push(ramp(20));
    check("full_in_ready", 0, 32'(d_rdy[0]), 32'd0);
    out_ready = 1'b1;
    repeat (16) step();
    for (int k = 0; k < 16; k++)
      check("b2b_fwd", 0, 32'(seen[0][k]), 32'((k < 8) ? (10 + k) : (12 + k)));
    check("b2b_drained", 0, 32'(d_vld[0]), 32'd0);

    // Boundary 7 -> 0 with a randomly stalling sink
    clear_seen();
    fork
      begin
        push(ramp(0));
        push(ramp(0));
      end
      begin
        for (int t = 0; t < 400 && seen[0].size() < 16; t++) begin
          out_ready = 1'($urandom_range(0, 1));
          step();
        end
      end
    join
    out_ready = 1'b1;
    wait_seen(16);
    for (int k = 0; k < 16; k++) check("bound_fwd", 0, 32'(seen[0][k]), 32'(k % 8));
    check("bound_err_fwd", 0, 32'(d_err[0]), 32'd0);
    check("bound_err_rev", 1, 32'(d_err[1]), 32'd0);

    // Out-of-order vector raises the sticky flag, which survives a clean vector
    clear_seen();
    v = ramp(0);
    v[3*DW +: DW] = 8'd9;
    push(v);
    wait_seen(8);
    check("err_set_fwd", 0, 32'(d_err[0]), 32'd1);
    check("err_set_rev", 1, 32'(d_err[1]), 32'd1);
    clear_seen();
    push(ramp(50));
    wait_seen(8);
    check("err_sticky_fwd", 0, 32'(d_err[0]), 32'd1);

    // Reset after three pops of a vector
    clear_seen();
    push(ramp(30));
    wait_seen(3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 0, 32'(d_vld[0]), 32'd0);
    check("mid_rst_ready", 0, 32'(d_rdy[0]), 32'd1);
    check("mid_rst_data", 0, 32'(d_data[0]), 32'd0);
    check("mid_rst_err", 0, 32'(d_err[0]), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    clear_seen();
    push(ramp(40));
    check("post_rst_idx", 0, 32'(d_idx[0]), 32'd0);
    check("post_rst_data", 0, 32'(d_data[0]), 32'd40);
    wait_seen(8);
    for (int k = 0; k < 8; k++) check("post_rst_seq", 0, 32'(seen[0][k]), 32'(40 + k));
    step();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "bench timeout");
  end
endmodule

// File: doc/bm_serializer.md
Name: bm_serializer

Overview:
- Downstream stage of the bitonic merger; consumes each merged vector of 2**LP elements in parallel and emits it as a serial element stream.
- Double-buffered (two vector slots), so the merger can deliver the next vector while the current one drains.
- Valid/ready handshake on both sides.
- Carries a sticky order checker that flags any element stream that is not monotonic in the direction given by DIR.

Parameters:
- LP, 3, log2 of elements per vector (PN = 2**LP, PN >= 2).
- DW, 8, element width in bits.
- DIR, 0, merger sort direction: 0 means the vector is ascending in index, 1 means descending.
- REV, 0, emission order: 0 emits index 0 first, then up to PN-1; 1 emits PN-1 first, then down to 0.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream vector valid.
- in_ready  out  1  a slot is free; vector accepted on in_valid & in_ready.
- in_data  in  PN*DW  merged vector; element i occupies bits [i*DW +: DW].
- out_valid  out  1  out_data holds a valid element.
- out_ready  in  1  downstream accepts the element on out_valid & out_ready.
- out_data  out  DW  current element.
- out_idx  out  LP  vector index of the current element.
- out_last  out  1  current element is the final one of its vector.
- sort_err  out  1  sticky order-violation flag.

Behaviour:
- State:
  - slot0, slot1: PN*DW each.
  - wr_ptr, rd_ptr: 1 bit each.
  - count: 0..2, number of full slots.
  - ecnt: LP bits, elements already emitted from the current slot.
  - prev: DW bits, last emitted element.
  - prev_v: 1 bit, prev is valid.
  - sort_err.
- Reset (async, rst_n low): all state registers clear to 0. Outputs after reset: in_ready=1, out_valid=0, out_last=0, out_idx=0, out_data=0, sort_err=0. Slot contents need not be cleared, but out_data must read 0 whenever count==0.
- Output decode (combinational from registers only):
  - in_ready = (count<2).
  - out_valid = (count>0).
  - out_idx = REV ? PN-1-ecnt : ecnt.
  - out_data = slot[rd_ptr][out_idx].
  - out_last = out_valid & (ecnt==PN-1).
- Accept (in_valid & in_ready at an edge): slot[wr_ptr] <= in_data; wr_ptr toggles; count increments.
- Pop (out_valid & out_ready at an edge):
  - If not last: ecnt increments.
  - If last: ecnt <= 0, rd_ptr toggles, count decrements.
- Accept and last-element pop at the same edge: count is unchanged, both pointers toggle.
- in_ready does not look ahead to a same-cycle pop. With count==2, in_ready=0 even if the last element is popping.
- Latency:
  - Vector accepted at edge k with count==0: first element is valid in the cycle after edge k.
  - Back-to-back vectors stream with no bubble: the last element of vector A is followed directly by the first of vector B.
  - Sustained throughput is 1 element/cycle.
- in_valid with in_ready=0: no state change. The upstream must hold its data.
- out_ready low: out_data, out_idx and out_last hold stable.
- Order checker, evaluated on each pop:
  - Required order: non-decreasing when DIR==REV, non-increasing otherwise. This applies only within a vector.
  - If prev_v is set and the element breaks the required order, sort_err <= 1.
  - Each pop sets prev <= out_data. prev_v <= 1 on a non-last pop and prev_v <= 0 on a last pop, so no comparison spans a vector boundary.
  - Equal elements are never an error.
  - sort_err clears only on reset.
- Reset mid-vector discards both slots and any partial emission. No element is replayed after reset.

Test Plan:
- LP=3, DW=8, DIR=0, REV=0. Reset, then push {0,1,...,7} (element i = i) with out_ready=1 → out_data 0..7 on consecutive cycles, out_last only with 7, sort_err=0.
- Push vector A={10..17}, then immediately B={20..27}, out_ready held 0 → in_ready drops to 0 after B. Then raise out_ready → 16 elements 10..17, 20..27 with no bubble between 17 and 20.
- REV=1, push {0..7} → emits 7,6,...,0 with out_idx 7→0; sort_err stays 0 (DIR≠REV, so non-increasing order is required).
- Push {0,1,2,9,4,5,6,7} → sort_err rises on the edge popping 4 and stays high through a following valid vector.
- Vector A ends with 7 and vector B starts with 0 → no error across the boundary. Toggling out_ready randomly leaves the data stream identical and out_data stable while stalled.
- Assert rst_n low after 3 elements have popped → outputs return to reset values immediately, and the next pushed vector emits from index 0.
